// File: rtl/nios_system_keys_servicer_if.sv
// rtl/nios_system_keys_servicer_if.sv - Avalon-MM PIO bus and key event stream bundle (KEYS_SVC_LEVEL_EN adds evt_level)
interface nios_system_keys_servicer_if #(
    parameter int DATA_WIDTH = 4
);
    logic [1:0]            avm_address;
    logic                  avm_chipselect;
    logic                  avm_write_n;
    logic [31:0]           avm_writedata;
    logic [31:0]           avm_readdata;
    logic                  evt_valid;
    logic                  evt_ready;
    logic [DATA_WIDTH-1:0] evt_keys;
`ifdef KEYS_SVC_LEVEL_EN
    logic [DATA_WIDTH-1:0] evt_level;
`endif

    modport master (
        output avm_address, avm_chipselect, avm_write_n, avm_writedata,
        output evt_valid, evt_keys,
`ifdef KEYS_SVC_LEVEL_EN
        output evt_level,
`endif
        input  avm_readdata, evt_ready
    );

    modport slave (
        input  avm_address, avm_chipselect, avm_write_n, avm_writedata,
        input  evt_valid, evt_keys,
`ifdef KEYS_SVC_LEVEL_EN
        input  evt_level,
`endif
        output avm_readdata, evt_ready
    );
endinterface

// File: rtl/nios_system_keys_servicer.sv
// rtl/nios_system_keys_servicer.sv - Avalon-MM servicer for the keys PIO irq; KEYS_SVC_LEVEL_EN adds a level read and evt_level
module nios_system_keys_servicer #(
    parameter int                    DATA_WIDTH    = 4,
    parameter logic [DATA_WIDTH-1:0] IRQ_MASK_INIT = 4'hF,
    parameter int                    READ_LATENCY  = 1
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        irq_in,
    input  logic                        mask_wr_req,
    input  logic [DATA_WIDTH-1:0]       mask_in,
    nios_system_keys_servicer_if.master bus
);
    typedef enum logic [2:0] {
        IDLE, MASK_WR, RD_ADDR, RD_WAIT,
`ifdef KEYS_SVC_LEVEL_EN
        RD_LVL_ADDR, RD_LVL_WAIT,
`endif
        CLR_WR, EVT
    } state_t;

    localparam logic [1:0] WAIT_LAST = 2'(READ_LATENCY - 1);

    state_t                state, state_nxt;
    logic [1:0]            wait_cnt;
    logic                  rd_last;
    logic [DATA_WIDTH-1:0] cap_q, cap_nxt;
    logic                  mask_pending;
    logic [DATA_WIDTH-1:0] pending_mask, active_mask;
    logic [1:0]            address_q, address_d;
    logic                  chipselect_q, chipselect_d;
    logic                  write_n_q, write_n_d;
    logic [31:0]           writedata_q, writedata_d;
    logic                  evt_valid_q;
    logic [DATA_WIDTH-1:0] evt_keys_q;
`ifdef KEYS_SVC_LEVEL_EN
    logic [DATA_WIDTH-1:0] lvl_q, evt_level_q;
`endif
    logic                  unused_rdata;

    assign unused_rdata = ^bus.avm_readdata[31:DATA_WIDTH];

    always_comb begin
        state_nxt    = state;
        rd_last      = (wait_cnt == WAIT_LAST);
        cap_nxt      = cap_q;
        address_d    = 2'd0;
        chipselect_d = 1'b0;
        write_n_d    = 1'b1;
        writedata_d  = '0;
        case (state)
            IDLE: begin
                if (mask_pending)
                    state_nxt = MASK_WR;
                else if (irq_in)
                    state_nxt = RD_ADDR;
            end
            MASK_WR: state_nxt = IDLE;
            RD_ADDR: state_nxt = RD_WAIT;
            RD_WAIT: begin
                if (rd_last) begin
                    cap_nxt = bus.avm_readdata[DATA_WIDTH-1:0] & active_mask;
                    if (cap_nxt == '0)
                        state_nxt = IDLE;
                    else
`ifdef KEYS_SVC_LEVEL_EN
                        state_nxt = RD_LVL_ADDR;
`else
                        state_nxt = CLR_WR;
`endif
                end
            end
`ifdef KEYS_SVC_LEVEL_EN
            RD_LVL_ADDR: state_nxt = RD_LVL_WAIT;
            RD_LVL_WAIT: if (rd_last) state_nxt = CLR_WR;
`endif
            CLR_WR: state_nxt = EVT;
            EVT:    if (bus.evt_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        // Bus outputs are decoded from the next state so they appear registered in that state's cycle
        case (state_nxt)
            MASK_WR: begin
                address_d    = 2'd2;
                chipselect_d = 1'b1;
                write_n_d    = 1'b0;
                writedata_d  = {{(32-DATA_WIDTH){1'b0}}, pending_mask};
            end
            RD_ADDR: begin
                address_d    = 2'd3;
                chipselect_d = 1'b1;
            end
`ifdef KEYS_SVC_LEVEL_EN
            RD_LVL_ADDR: begin
                address_d    = 2'd0;
                chipselect_d = 1'b1;
            end
`endif
            CLR_WR: begin
                address_d    = 2'd3;
                chipselect_d = 1'b1;
                write_n_d    = 1'b0;
                writedata_d  = {{(32-DATA_WIDTH){1'b0}}, cap_nxt};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            wait_cnt     <= 2'd0;
            cap_q        <= '0;
            mask_pending <= 1'b1;
            pending_mask <= IRQ_MASK_INIT;
            active_mask  <= '0;
            address_q    <= 2'd0;
            chipselect_q <= 1'b0;
            write_n_q    <= 1'b1;
            writedata_q  <= '0;
            evt_valid_q  <= 1'b0;
            evt_keys_q   <= '0;
`ifdef KEYS_SVC_LEVEL_EN
            lvl_q        <= '0;
            evt_level_q  <= '0;
`endif
        end else begin
            state        <= state_nxt;
            wait_cnt     <= (state_nxt == state) ? wait_cnt + 2'd1 : 2'd0;
            cap_q        <= cap_nxt;
            address_q    <= address_d;
            chipselect_q <= chipselect_d;
            write_n_q    <= write_n_d;
            writedata_q  <= writedata_d;
            evt_valid_q  <= (state_nxt == EVT);
            if (state == CLR_WR)
                evt_keys_q <= cap_q;
`ifdef KEYS_SVC_LEVEL_EN
            if (state == RD_LVL_WAIT && rd_last)
                lvl_q <= bus.avm_readdata[DATA_WIDTH-1:0];
            if (state == CLR_WR)
                evt_level_q <= lvl_q;
`endif
            if (state == IDLE && state_nxt == MASK_WR) begin
                mask_pending <= 1'b0;
                active_mask  <= pending_mask;
            end
            // A request in the same cycle as the mask write re-arms it, so the last request wins
            if (mask_wr_req) begin
                mask_pending <= 1'b1;
                pending_mask <= mask_in;
            end
        end
    end

    assign bus.avm_address    = address_q;
    assign bus.avm_chipselect = chipselect_q;
    assign bus.avm_write_n    = write_n_q;
    assign bus.avm_writedata  = writedata_q;
    assign bus.evt_valid      = evt_valid_q;
    assign bus.evt_keys       = evt_keys_q;
`ifdef KEYS_SVC_LEVEL_EN
    assign bus.evt_level      = evt_level_q;
`endif
endmodule

// File: tb/tb_nios_system_keys_servicer.sv
// tb/tb_nios_system_keys_servicer.sv - self-checking bench with keys PIO model for nios_system_keys_servicer
module tb_nios_system_keys_servicer;
    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          irq_in;
    logic          mask_wr_req = 1'b0;
    logic [DW-1:0] mask_in = '0;
    logic [DW-1:0] inject = '0;
    logic          force_irq = 1'b0;
    logic [DW-1:0] pio_edge = '0;
    logic [DW-1:0] pio_mask = '0;
    logic [31:0]   pio_rd = '0;
    int            n_mask_wr = 0;
    int            n_clr_wr = 0;
    logic [31:0]   last_mask_wd = '0;
    logic [31:0]   last_clr_wd = '0;
    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] pend;
    logic [DW-1:0] cur_mask;

    typedef struct {
        logic [3:0] mask;
        logic [3:0] press;
        int         dly;
        logic [3:0] exp;
    } vec_t;
    vec_t tbl[8];

    nios_system_keys_servicer_if #(.DATA_WIDTH(DW)) bus ();

    nios_system_keys_servicer #(
        .DATA_WIDTH(DW),
        .IRQ_MASK_INIT(4'hF),
        .READ_LATENCY(1)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .irq_in(irq_in),
        .mask_wr_req(mask_wr_req),
        .mask_in(mask_in),
        .bus(bus.master)
    );

    always #5 clk = ~clk;

    assign irq_in = force_irq | (|(pio_edge & pio_mask));
    assign bus.avm_readdata = pio_rd;

    // Keys PIO responder: bit-clearing edge capture, registered readdata, plus a write monitor
    always @(posedge clk) begin
        if (!reset_n) begin
            pio_edge <= '0;
            pio_mask <= '0;
            pio_rd   <= '0;
        end else begin
            if (bus.avm_chipselect && !bus.avm_write_n && bus.avm_address == 2'd3)
                pio_edge <= (pio_edge & ~bus.avm_writedata[DW-1:0]) | inject;
            else
                pio_edge <= pio_edge | inject;
            if (bus.avm_chipselect && !bus.avm_write_n && bus.avm_address == 2'd2)
                pio_mask <= bus.avm_writedata[DW-1:0];
            if (bus.avm_chipselect && bus.avm_write_n)
                pio_rd <= (bus.avm_address == 2'd3) ? {28'b0, pio_edge} :
                          (bus.avm_address == 2'd2) ? {28'b0, pio_mask} : 32'b0;
            if (bus.avm_chipselect && !bus.avm_write_n) begin
                if (bus.avm_address == 2'd2) begin
                    n_mask_wr++;
                    last_mask_wd = bus.avm_writedata;
                end
                if (bus.avm_address == 2'd3) begin
                    n_clr_wr++;
                    last_clr_wd = bus.avm_writedata;
                end
            end
        end
    end

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_event(input logic [3:0] exp, input int dly, output logic [3:0] got);
        int  n0;
        int  t;
        bit  seen;
        got  = '0;
        n0   = n_clr_wr;
        seen = 1'b0;
        if (exp == 4'h0) begin
            for (int i = 0; i < 12; i++) begin
                nxt();
                if (bus.evt_valid) seen = 1'b1;
            end
            chk("no_event_valid", seen, 0);
            chk("no_clear_write", n_clr_wr - n0, 0);
        end else begin
            t = 0;
            while (!bus.evt_valid && t < 30) begin
                nxt();
                t++;
            end
            if (!bus.evt_valid) begin
                chk("event_timeout", 0, 1);
                return;
            end
            got = bus.evt_keys;
            chk("evt_keys", bus.evt_keys, exp);
            chk("clear_count", n_clr_wr - n0, 1);
            chk("clear_wdata", last_clr_wd, {28'b0, exp});
            for (int i = 0; i < dly; i++) begin
                nxt();
                chk("evt_hold", {bus.evt_valid, bus.evt_keys}, {1'b1, exp});
            end
            bus.evt_ready = 1'b1;
            nxt();
            bus.evt_ready = 1'b0;
            chk("evt_drop", bus.evt_valid, 0);
        end
    endtask

    task automatic do_step(input logic [3:0] mask, input logic [3:0] press, input int dly,
                           output logic [3:0] got_all);
        logic [3:0] exp;
        logic [3:0] got;
        int         n0;
        int         t;
        got_all = '0;
        if (mask != cur_mask) begin
            n0          = n_mask_wr;
            mask_in     = mask;
            mask_wr_req = 1'b1;
            nxt();
            mask_wr_req = 1'b0;
            t = 0;
            while (n_mask_wr == n0 && t < 20) begin
                nxt();
                t++;
            end
            chk("mask_write_seen", n_mask_wr != n0, 1);
            chk("mask_wdata", last_mask_wd, {28'b0, mask});
            cur_mask = mask;
            exp = pend & cur_mask;
            if (exp != 4'h0) begin
                expect_event(exp, dly, got);
                got_all |= got;
                pend &= ~exp;
            end
        end
        if (press != 4'h0) begin
            inject = press;
            nxt();
            inject = '0;
            pend |= press;
            exp = pend & cur_mask;
            expect_event(exp, dly, got);
            got_all |= got;
            pend &= ~exp;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [3:0] got;
        int         n0;
        int         t;
        bit         seen;
        int         cs_cnt;
        logic [3:0] m;
        logic [3:0] p;

        tbl[0] = '{4'hF, 4'h1, 0, 4'h1};
        tbl[1] = '{4'hF, 4'h8, 2, 4'h8};
        tbl[2] = '{4'hF, 4'h6, 1, 4'h6};
        tbl[3] = '{4'h3, 4'hC, 0, 4'h0};
        tbl[4] = '{4'hF, 4'h0, 0, 4'hC};
        tbl[5] = '{4'hA, 4'hF, 3, 4'hA};
        tbl[6] = '{4'hF, 4'h0, 1, 4'h5};
        tbl[7] = '{4'hF, 4'hF, 0, 4'hF};

        bus.evt_ready = 1'b0;
        pend     = '0;
        cur_mask = 4'hF;

        // Reset state and the initial mask write
        repeat (3) nxt();
        chk("reset_outputs",
            {bus.avm_address, bus.avm_chipselect, bus.avm_write_n, bus.avm_writedata, bus.evt_valid, bus.evt_keys},
            {2'd0, 1'b0, 1'b1, 32'h0, 1'b0, 4'h0});
        reset_n = 1'b1;
        nxt();
        chk("init_mask_write", {bus.avm_address, bus.avm_chipselect, bus.avm_write_n, bus.avm_writedata},
            {2'd2, 1'b1, 1'b0, 32'h0000000F});
        nxt();
        chk("idle_after_mask", {bus.avm_chipselect, bus.avm_write_n}, {1'b0, 1'b1});

        // key[1] edge: cycle-exact latency
        nxt();
        inject = 4'b0010;
        nxt();
        inject = '0;
        chk("irq_raised", irq_in, 1);
        nxt();
        chk("rd_addr", {bus.avm_address, bus.avm_chipselect, bus.avm_write_n}, {2'd3, 1'b1, 1'b1});
        nxt();
        chk("rd_wait_cs", bus.avm_chipselect, 0);
        nxt();
        chk("clr_wr", {bus.avm_address, bus.avm_chipselect, bus.avm_write_n, bus.avm_writedata},
            {2'd3, 1'b1, 1'b0, 32'h2});
        nxt();
        chk("evt_at_i4", {bus.evt_valid, bus.evt_keys}, {1'b1, 4'b0010});
        chk("irq_cleared", irq_in, 0);

        // Back-pressure for 10 cycles while key[0] edge arrives
        for (int i = 0; i < 10; i++) begin
            inject = (i == 3) ? 4'b0001 : 4'b0000;
            nxt();
            chk("evt_stall_hold", {bus.evt_valid, bus.evt_keys}, {1'b1, 4'b0010});
        end
        inject = '0;
        bus.evt_ready = 1'b1;
        nxt();
        bus.evt_ready = 1'b0;
        chk("evt_stall_drop", bus.evt_valid, 0);
        expect_event(4'b0001, 0, got);
        chk("second_event", got, 4'b0001);

        // Mask request during RD_WAIT is deferred until the event completes
        inject = 4'b0001;
        nxt();
        inject = '0;
        nxt();
        nxt();
        chk("in_rd_wait", {bus.avm_chipselect, bus.avm_write_n}, {1'b0, 1'b1});
        mask_in     = 4'b0100;
        mask_wr_req = 1'b1;
        nxt();
        mask_wr_req = 1'b0;
        n0 = n_mask_wr;
        nxt();
        chk("evt_before_mask", {bus.evt_valid, bus.evt_keys}, {1'b1, 4'b0001});
        bus.evt_ready = 1'b1;
        nxt();
        bus.evt_ready = 1'b0;
        chk("evt_drop_mask", bus.evt_valid, 0);
        chk("mask_deferred", n_mask_wr - n0, 0);
        t = 0;
        while (n_mask_wr == n0 && t < 10) begin
            nxt();
            t++;
        end
        chk("mask4_written", n_mask_wr - n0, 1);
        chk("mask4_wdata", last_mask_wd, 32'h4);
        cur_mask = 4'b0100;
        do_step(4'b0100, 4'b0001, 0, got);
        chk("masked_key0", got, 4'h0);

        // Spurious irq: read, no clear, no event, back to idle
        n0 = n_clr_wr;
        force_irq = 1'b1;
        nxt();
        force_irq = 1'b0;
        chk("spur_rd_addr", {bus.avm_address, bus.avm_chipselect, bus.avm_write_n}, {2'd3, 1'b1, 1'b1});
        seen = 1'b0;
        cs_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            nxt();
            if (bus.evt_valid) seen = 1'b1;
            if (bus.avm_chipselect) cs_cnt++;
        end
        chk("spur_no_evt", seen, 0);
        chk("spur_no_clear", n_clr_wr - n0, 0);
        chk("spur_idle", cs_cnt, 0);

        // Reset during CLR_WR
        inject = 4'b0100;
        nxt();
        inject = '0;
        t = 0;
        while (!(bus.avm_chipselect && !bus.avm_write_n && bus.avm_address == 2'd3) && t < 20) begin
            nxt();
            t++;
        end
        chk("reach_clr_wr", t < 20, 1);
        reset_n = 1'b0;
        nxt();
        chk("rst_abort", {bus.evt_valid, bus.avm_chipselect}, 2'b00);
        nxt();
        reset_n = 1'b1;
        nxt();
        chk("mask_rewrite", {bus.avm_address, bus.avm_chipselect, bus.avm_write_n, bus.avm_writedata},
            {2'd2, 1'b1, 1'b0, 32'h0000000F});
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            nxt();
            if (bus.evt_valid) seen = 1'b1;
        end
        chk("no_evt_after_reset", seen, 0);
        pend     = '0;
        cur_mask = 4'hF;

        // Table-driven vectors
        for (int i = 0; i < 8; i++) begin
            do_step(tbl[i].mask, tbl[i].press, tbl[i].dly, got);
            chk($sformatf("tbl%0d_keys", i), got, tbl[i].exp);
        end

        // Randomized mask changes and key presses against the edge-capture model
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                m = 4'($urandom_range(0, 15));
                p = 4'h0;
            end else begin
                m = cur_mask;
                p = 4'($urandom_range(1, 15));
            end
            do_step(m, p, $urandom_range(0, 3), got);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
